dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port data memory (dcache) of the single-cycle core.
- Port 0 is the core load/store path; port 1 is the program/debug loader that fills or inspects data memory while the core runs or is stalled.
- Grants one access per cycle, tracks which requester owns each outstanding read, and routes the one-cycle-late read data back to that owner.
- Round-robin or fixed priority, selected by parameter.

Parameters:
- AW, 6, word-address width; matches the 64-word data memory.
- DW, 32, data width.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- p0_req_i  in  1  port 0 access request.
- p0_we_i  in  1  port 0 write (1) / read (0).
- p0_addr_i  in  AW  port 0 word address.
- p0_wdata_i  in  DW  port 0 write data.
- p0_gnt_o  out  1  port 0 request accepted this cycle.
- p0_rvalid_o  out  1  port 0 read data valid.
- p0_rdata_o  out  DW  port 0 read data.
- p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_gnt_o, p1_rvalid_o, p1_rdata_o: same as port 0, for port 1.
- mem_re_o  out  1  memory read enable.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  AW  memory word address.
- mem_wdata_o  out  DW  memory write data.
- mem_rdata_i  in  DW  memory read data, valid the cycle after mem_re_o.

Behaviour:
- Reset (rst_i high, asynchronous): last_q=1 so port 0 wins the first tie; rd_pend_q=0; rd_owner_q=0.
  - While reset is high: gnt_o=0, rvalid_o=0, rdata_o=0 on both ports; mem_re_o=mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Arbitration is combinational within cycle T.
  - Only one port requesting: that port is granted.
  - Both requesting, FIXED_PRIO=1: port 0 is granted.
  - Both requesting, FIXED_PRIO=0: the port not equal to last_q is granted.
  - At most one gnt_o is high per cycle; gnt_o never rises without its req_i.
- On a grant, the granted port's addr/wdata/we drive the memory in cycle T.
  - mem_we_o = granted & we; mem_re_o = granted & !we.
  - No grant: all memory outputs are 0.
- State updates at the edge ending T:
  - last_q <= granted port; unchanged when there is no grant.
  - rd_pend_q <= granted & !we.
  - rd_owner_q <= granted port, when a read is granted.
- Read latency is exactly 1 cycle. In cycle T+1, if rd_pend_q is set:
  - pN_rvalid_o=1 for N=rd_owner_q;
  - pN_rdata_o = mem_rdata_i.
  - The other port's rvalid_o=0 and rdata_o=0. With rd_pend_q clear, rdata_o=0 on both ports.
- Writes complete at the granting edge. No response is returned for a write.
- Throughput: a new grant is allowed in T+1 while the T read response is being returned, giving back-to-back accesses at 1 per cycle.
- Requester rule: req_i, we_i, addr_i and wdata_i must stay stable until gnt_o is seen. Dropping req_i before the grant withdraws the request; this is legal and leaves no side effect.
- Fairness: in round-robin mode, a continuously requesting port is granted within 2 cycles.
- Port 0 stall contract: the core treats p0_req_i & !p0_gnt_o as a pipeline stall, freezing the PC and blocking register-file write.
- Reset mid-operation: a pending read response is discarded (rvalid stays 0), and a write in the reset cycle is suppressed.
- Same-address collisions between ports are serialized by grant order. A read granted in the cycle after a write to the same address returns the new data.

Test Plan:
- Single reads: p0 reads addr 5, memory holds 0xDEADBEEF → p0_gnt_o=1 in T; p0_rvalid_o=1, p0_rdata_o=0xDEADBEEF in T+1; p1 outputs stay 0.
- Simultaneous requests, round-robin, from reset: both ports request reads continuously for 4 cycles → grant order p0,p1,p0,p1; each rvalid goes to its owner 1 cycle later.
- FIXED_PRIO=1: both ports request for 3 cycles → p0 granted every cycle, p1_gnt_o=0; p1 is granted in the first cycle p0_req_i=0.
- Write then read: p1 writes 0x12345678 to addr 10 in T; p0 reads addr 10 in T+1 → p0_rdata_o=0x12345678 in T+2; no rvalid is produced for the write.
- Reset mid-read: p0 read granted in T, rst_i asserted mid-T+1 → p0_rvalid_o drops to 0 immediately. After release, both ports request → p0 granted first.
- Withdrawn request: p1 raises req, loses to p0, then drops req → no p1 grant and no memory write. The memory contents at the p1 address are unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter in front of the single-port data memory.
//   Port 0 : core load/store path (p0_req_i & !p0_gnt_o stalls the core)
//   Port 1 : program/debug loader
// One access is granted per cycle and drives the memory combinationally in
// that cycle. A granted read returns its data one cycle later, and only to the
// port that issued it. Writes finish at the granting edge and give no response.
//
// Parameters
//   AW         word-address width (64-word memory by default)
//   DW         data width
//   FIXED_PRIO 0 = round-robin between the ports, 1 = port 0 always wins
//
// Ports
//   clk_i, rst_i                        clock, async active-high reset
//   pN_req_i/we_i/addr_i/wdata_i        request from port N
//   pN_gnt_o                            request of port N accepted this cycle
//   pN_rvalid_o/rdata_o                 read response for port N
//   mem_re_o/we_o/addr_o/wdata_o        memory command
//   mem_rdata_i                         memory read data, one cycle after mem_re_o
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW         = 6,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          p0_req_i,
    input  logic          p0_we_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wdata_i,
    output logic          p0_gnt_o,
    output logic          p0_rvalid_o,
    output logic [DW-1:0] p0_rdata_o,

    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    output logic          p1_gnt_o,
    output logic          p1_rvalid_o,
    output logic [DW-1:0] p1_rdata_o,

    output logic          mem_re_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    // r_last     : port granted most recently (1 after reset so port 0 wins the first tie)
    // r_rd_pend  : a read was granted last cycle; its data is on mem_rdata_i now
    // r_rd_owner : port that issued that read
    logic          r_last;
    logic          r_rd_pend;
    logic          r_rd_owner;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any;
    logic          w_sel;
    logic          w_we;
    logic          w_rvalid;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // Grant decision. Everything is held off while reset is asserted so that a
    // write presented in a reset cycle never reaches the memory.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst_i) begin
            if (p0_req_i && p1_req_i) begin
                // Tie: fixed priority favours port 0; round-robin favours the
                // port that was not served last.
                if ((FIXED_PRIO != 0) || r_last) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = p0_req_i;
                w_gnt1 = p1_req_i;
            end
        end
    end

    assign w_any   = w_gnt0 | w_gnt1;
    assign w_sel   = w_gnt1;
    assign w_we    = w_sel ? p1_we_i    : p0_we_i;
    assign w_addr  = w_sel ? p1_addr_i  : p0_addr_i;
    assign w_wdata = w_sel ? p1_wdata_i : p0_wdata_i;

    assign p0_gnt_o    = w_gnt0;
    assign p1_gnt_o    = w_gnt1;

    // Memory bus is quiet (all zero) whenever nothing is granted.
    assign mem_we_o    = w_any & w_we;
    assign mem_re_o    = w_any & ~w_we;
    assign mem_addr_o  = w_any ? w_addr  : '0;
    assign mem_wdata_o = w_any ? w_wdata : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last     <= 1'b1;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            if (w_any) begin
                r_last <= w_sel;
            end
            r_rd_pend <= w_any & ~w_we;
            if (w_any && !w_we) begin
                r_rd_owner <= w_sel;
            end
        end
    end

    // Response path. Gating with rst_i drops a pending response the moment
    // reset is raised, without waiting for the register to clear.
    assign w_rvalid    = r_rd_pend & ~rst_i;
    assign p0_rvalid_o = w_rvalid & ~r_rd_owner;
    assign p1_rvalid_o = w_rvalid &  r_rd_owner;
    assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : '0;
    assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : '0;

endmodule
